psg_bus_arb_n: RTL and testbench

PSG_BUS_ARB_N -- requirements
Module: psg_bus_arb_n

---
 rtl/psg_arb_pkg.sv | 16 +
 rtl/psg_arb_pick.sv | 36 +++
 rtl/psg_bus_arb_n.sv | 91 +++++++++
 tb/tb_psg_bus_arb_n.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/psg_arb_pkg.sv
// Shared constants and helpers for the psg bus arbiter: channel-count limits,
// owner-index width and default watchdog limit.
package psg_arb_pkg;

  localparam int NCH_MIN     = 2;
  localparam int NCH_MAX     = 16;
  localparam int TMO_DEFAULT = 255;
  localparam int TMO_MAX     = 65535;
  localparam int CNT_W       = 16;

  // Width of the owner index; never below one bit.
  function automatic int seln_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psg_arb_pick.sv
// Combinational rotating-mask priority picker: the first asserted request at
// or above i_start wins, otherwise the search wraps to the lowest request.
import psg_arb_pkg::*;

module psg_arb_pick #(
  parameter int NCH = 8,
  parameter int SW  = seln_w(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [SW-1:0]  i_start,
  output logic [NCH-1:0] o_gnt,
  output logic [SW-1:0]  o_idx,
  output logic           o_any
);

  localparam logic [NCH-1:0] ONE = NCH'(1);

  logic [NCH-1:0] w_mask;
  logic [NCH-1:0] w_hi;
  logic [NCH-1:0] w_src;

  // Bits at or above the start index; the wrap falls back to the full vector.
  assign w_mask = ~((ONE << i_start) - ONE);
  assign w_hi   = i_req & w_mask;
  assign w_src  = (|w_hi) ? w_hi : i_req;
  assign o_gnt  = w_src & (~w_src + ONE);
  assign o_any  = |i_req;

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (o_gnt[i]) o_idx = o_idx | SW'(i);
    end
  end

endmodule

// File: rtl/psg_bus_arb_n.sv
// N-channel bus arbiter, fixed or round-robin priority, with optional
// watchdog re-arbitration compiled in by defining PSG_ARB_WDOG_EN.
import psg_arb_pkg::*;

module psg_bus_arb_n #(
  parameter int NCH = 8,
  parameter int RR  = 1,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    ack,
  input  logic [NCH-1:0]          req,
  output logic [NCH-1:0]          sel,
  output logic [seln_w(NCH)-1:0]  seln,
  output logic                    gnt_vld,
  output logic                    timeout
);

  localparam int SW = seln_w(NCH);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TMO);

  logic [NCH-1:0] r_sel;
  logic [SW-1:0]  r_seln;
  logic           r_gnt_vld;

  logic           w_expire;
  logic           w_event;
  logic [SW-1:0]  w_start;
  logic [NCH-1:0] w_gnt;
  logic [SW-1:0]  w_idx;
  logic           w_any;

  // Handshake: ack is a level qualified by ce; each cycle with ce & ack ends the
  // current transfer and re-arbitrates, ack with ce low is dropped, not stored.
  assign w_event = ce & (ack | w_expire);

  // Round-robin searches from the slot after the owner; before any grant, from 0.
  assign w_start = (RR != 0 && r_gnt_vld)
                   ? ((r_seln == SW'(NCH - 1)) ? '0 : r_seln + SW'(1))
                   : '0;

  psg_arb_pick #(.NCH(NCH), .SW(SW)) u_pick (
    .i_req   (req),
    .i_start (w_start),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel     <= '0;
      r_seln    <= '0;
      r_gnt_vld <= 1'b0;
    end else if (w_event && w_any) begin
      r_sel     <= w_gnt;
      r_seln    <= w_idx;
      r_gnt_vld <= 1'b1;
    end
  end

`ifdef PSG_ARB_WDOG_EN
  logic [CNT_W-1:0] r_wcnt;

  assign w_expire = ce & (r_wcnt == TMO_C);
  // An ack landing in the expiry cycle is a normal completion, so no pulse.
  assign timeout  = w_expire & ~ack & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if (ce) begin
      if (ack || w_expire) r_wcnt <= '0;
      else if (r_gnt_vld && r_wcnt != TMO_C) r_wcnt <= r_wcnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_tmo;

  assign w_unused_tmo = ^TMO_C;
  assign w_expire     = 1'b0;
  assign timeout      = 1'b0;
`endif

  assign sel     = r_sel;
  assign seln    = r_seln;
  assign gnt_vld = r_gnt_vld;

endmodule

// File: tb/tb_psg_bus_arb_n.sv
// Bench for psg_bus_arb_n: fixed-priority and round-robin instances share
// stimulus; a cycle model feeds an expected-value queue checked after each edge.
module tb_psg_bus_arb_n;

  localparam int NCH = 8;
  localparam int SW  = 3;
  localparam int TMO = 4;
  localparam int W   = 24;
`ifdef PSG_ARB_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           ce  = 1'b0;
  logic           ack = 1'b0;
  logic [NCH-1:0] req = '0;

  logic [NCH-1:0] sel_f, sel_r;
  logic [SW-1:0]  seln_f, seln_r;
  logic           vld_f, vld_r, to_f, to_r;

  psg_bus_arb_n #(.NCH(NCH), .RR(0), .TMO(TMO)) u_fp (
    .clk(clk), .rst(rst), .ce(ce), .ack(ack), .req(req),
    .sel(sel_f), .seln(seln_f), .gnt_vld(vld_f), .timeout(to_f)
  );

  psg_bus_arb_n #(.NCH(NCH), .RR(1), .TMO(TMO)) u_rr (
    .clk(clk), .rst(rst), .ce(ce), .ack(ack), .req(req),
    .sel(sel_r), .seln(seln_r), .gnt_vld(vld_r), .timeout(to_r)
  );

  // scoreboard and reference state
  logic [W-1:0] exp_q[$];
  int checks  = 0;
  int errors  = 0;
  int to_seen = 0;

  logic [7:0] m_sel_f  = '0;
  logic [7:0] m_sel_r  = '0;
  logic [2:0] m_seln_f = '0;
  logic [2:0] m_seln_r = '0;
  logic       m_vld    = 1'b0;
  int         m_cnt    = 0;

  task automatic model_pick(input logic [7:0] q, input int start,
                            output logic [7:0] g, output logic [2:0] ix);
    bit found;
    found = 1'b0;
    g  = '0;
    ix = '0;
    for (int i = 0; i < NCH; i++) begin
      int k;
      k = (start + i) % NCH;
      if (!found && ((q >> k) & 8'd1) != 8'd0) begin
        found = 1'b1;
        g  = 8'd1 << k;
        ix = 3'(k);
      end
    end
  endtask

  // driver: one clock cycle of stimulus, model step, and scoreboard check
  task automatic cycle(input logic r, input logic c, input logic a,
                       input logic [7:0] q, input string tag);
    logic       expire, exp_to, ev;
    logic [7:0] g;
    logic [2:0] ix;
    logic [W-1:0] e, got;
    rst = r; ce = c; ack = a; req = q;
    #1;
    expire = WD_EN && c && (m_cnt == TMO);
    exp_to = expire && !a && !r;
    checks++;
    if (to_f !== exp_to || to_r !== exp_to) begin
      errors++;
      $display("FAIL %s timeout: got fp=%b rr=%b want %b", tag, to_f, to_r, exp_to);
    end
    if (to_r === 1'b1) to_seen++;
    if (r) begin
      m_sel_f = '0; m_sel_r = '0; m_seln_f = '0; m_seln_r = '0;
      m_vld = 1'b0; m_cnt = 0;
    end else if (c) begin
      ev = a || expire;
      if (ev) m_cnt = 0;
      else if (m_vld && m_cnt < TMO) m_cnt++;
      if (ev && q != 8'd0) begin
        model_pick(q, 0, g, ix);
        m_sel_f = g; m_seln_f = ix;
        model_pick(q, m_vld ? (int'(m_seln_r) + 1) % NCH : 0, g, ix);
        m_sel_r = g; m_seln_r = ix;
        m_vld = 1'b1;
      end
    end
    exp_q.push_back({m_sel_f, m_seln_f, m_vld, m_sel_r, m_seln_r, m_vld});
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = {sel_f, seln_f, vld_f, sel_r, seln_r, vld_r};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s outputs {sel_f,seln_f,vld_f,sel_r,seln_r,vld_r}: got %h want %h",
               tag, got, e);
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h00, "reset_idle");
    cycle(1'b1, 1'b1, 1'b1, 8'hFF, "reset_over_event");
    checks++;
    if (sel_r !== 8'h00 || seln_r !== 3'd0 || vld_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got sel=%b seln=%0d vld=%b want 0/0/0", sel_r, seln_r, vld_r);
    end
  endtask

  task automatic test_fixed_prio();
    cycle(1'b0, 1'b1, 1'b1, 8'b1010_0100, "fixed_first");
    checks++;
    if (sel_f !== 8'b0000_0100 || seln_f !== 3'd2 || vld_f !== 1'b1) begin
      errors++;
      $display("FAIL fixed_first_const: got sel=%b seln=%0d vld=%b want 00000100/2/1",
               sel_f, seln_f, vld_f);
    end
    cycle(1'b0, 1'b1, 1'b1, 8'b1010_0100, "fixed_repeat");
    checks++;
    if (seln_f !== 3'd2) begin
      errors++;
      $display("FAIL fixed_repeat_const: got seln=%0d want 2", seln_f);
    end
  endtask

  task automatic test_rr_rotation();
    cycle(1'b0, 1'b1, 1'b1, 8'b0010_0000, "rr_own5");
    cycle(1'b0, 1'b1, 1'b1, 8'b0010_0001, "rr_wrap");
    checks++;
    if (seln_r !== 3'd0 || sel_r !== 8'b0000_0001) begin
      errors++;
      $display("FAIL rr_wrap_const: got seln=%0d sel=%b want 0/00000001", seln_r, sel_r);
    end
    cycle(1'b0, 1'b1, 1'b1, 8'b0010_0001, "rr_next");
    checks++;
    if (seln_r !== 3'd5 || seln_f !== 3'd0) begin
      errors++;
      $display("FAIL rr_next_const: got rr=%0d fp=%0d want 5/0", seln_r, seln_f);
    end
  endtask

  task automatic test_park();
    cycle(1'b0, 1'b1, 1'b1, 8'b0000_1000, "park_own3");
    cycle(1'b0, 1'b1, 1'b1, 8'b0000_0000, "park_noreq");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'hFF, "park_ce0");
      checks++;
      if (sel_r !== 8'b0000_1000 || seln_r !== 3'd3 || sel_f !== 8'b0000_1000) begin
        errors++;
        $display("FAIL park_hold_const: got rr sel=%b seln=%0d fp sel=%b want 00001000/3",
                 sel_r, seln_r, sel_f);
      end
    end
  endtask

  task automatic test_watchdog();
    cycle(1'b0, 1'b1, 1'b1, 8'b0000_0010, "wd_own1");
    to_seen = 0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'b0000_0110, "wd_stall");
    checks++;
    if (to_seen != (WD_EN ? 1 : 0) || seln_r !== (WD_EN ? 3'd2 : 3'd1) || seln_f !== 3'd1) begin
      errors++;
      $display("FAIL wd_expire: got pulses=%0d rr=%0d fp=%0d want %0d/%0d/1",
               to_seen, seln_r, seln_f, WD_EN ? 1 : 0, WD_EN ? 2 : 1);
    end
    cycle(1'b0, 1'b1, 1'b1, 8'b0000_0010, "wd_own1_again");
    to_seen = 0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'b0000_0110, "wd_stall2");
    cycle(1'b0, 1'b1, 1'b1, 8'b0000_0110, "wd_ack_coincide");
    checks++;
    if (to_seen != 0 || seln_r !== 3'd2) begin
      errors++;
      $display("FAIL wd_ack_coincide: got pulses=%0d rr=%0d want 0/2", to_seen, seln_r);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic       r, c, a;
      logic [7:0] q;
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 3) == 0);
      q = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      cycle(r, c, a, q, "random");
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 1'b1, 8'b0100_0000, "mid_own6");
    cycle(1'b1, 1'b1, 1'b1, 8'hFF, "mid_reset");
    checks++;
    if (sel_r !== 8'h00 || seln_r !== 3'd0 || vld_r !== 1'b0 || vld_f !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_const: got sel=%b seln=%0d vld=%b/%b want 0/0/0",
               sel_r, seln_r, vld_r, vld_f);
    end
    cycle(1'b0, 1'b1, 1'b1, 8'hFF, "post_reset_grant");
    checks++;
    if (seln_r !== 3'd0 || sel_r !== 8'b0000_0001 || vld_r !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_grant_const: got sel=%b seln=%0d vld=%b want 00000001/0/1",
               sel_r, seln_r, vld_r);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_prio();
    test_rr_rotation();
    test_park();
    test_watchdog();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
